// File: rtl/mantis_add_normalize_pkg.sv
// Shared widths, FSM state encoding and result payload for the add/normalize stage.
package mantis_add_normalize_pkg;

    localparam int unsigned EXP_SIZE    = 8;
    localparam int unsigned MANTIS_SIZE = 23;
    localparam int unsigned W           = MANTIS_SIZE + 3;
    localparam int unsigned LZC_N       = W - 1;
    localparam int unsigned LZC_W       = $clog2(LZC_N + 1);

    localparam logic [EXP_SIZE-1:0] EXP_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_NORM = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef struct packed {
        logic                sign;
        logic [EXP_SIZE-1:0] exp;
        logic [W-1:0]        mantis;
        logic                loss;
        logic                overflow;
        logic                zero;
    } result_t;

endpackage

// File: rtl/mantis_add_normalize_lzc.sv
// Combinational leading-zero counter; returns N when the vector is all zeros.
module mantis_add_normalize_lzc #(
    parameter int unsigned N  = 25,
    parameter int unsigned CW = $clog2(N + 1)
) (
    input  logic [N-1:0]  vec_i,
    output logic [CW-1:0] count_o
);

    // Scan upward so the highest set bit wins.
    always_comb begin
        count_o = CW'(N);
        for (int i = 0; i < int'(N); i++) begin
            if (vec_i[i]) begin
                count_o = CW'(int'(N) - 1 - i);
            end
        end
    end

endmodule

// File: rtl/mantis_add_normalize.sv
// Effective add/subtract of aligned mantissas followed by normalization.
// FPA_FAST_NORM_EN selects single-cycle LZC normalization instead of 1 bit/cycle.
module mantis_add_normalize
    import mantis_add_normalize_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                sign_of_great,
    input  logic                sign_of_small,
    input  logic [EXP_SIZE-1:0] exp,
    input  logic [W-1:0]        mantis_great,
    input  logic [W-1:0]        mantis_small,
    input  logic                loss_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                sign_out,
    output logic [EXP_SIZE-1:0] exp_out,
    output logic [W-1:0]        mantis_out,
    output logic                loss_out,
    output logic                overflow,
    output logic                zero
);

    state_e        state_q, state_d;
    result_t       res_q, res_d;
    logic [W-1:0]  small_q, small_d;
    logic          sub_q, sub_d;
    logic [EXP_SIZE:0] exp_inc;

    // Extra bit lets the carry path detect both all-ones and wrap-around.
    assign exp_inc = {1'b0, res_q.exp} + (EXP_SIZE + 1)'(1);

`ifdef FPA_FAST_NORM_EN
    logic [LZC_W-1:0]    lz;
    logic [EXP_SIZE-1:0] lz_ext;
    logic [EXP_SIZE-1:0] exp_m1;
    logic [EXP_SIZE-1:0] shamt;

    mantis_add_normalize_lzc #(
        .N  (LZC_N),
        .CW (LZC_W)
    ) u_lzc (
        .vec_i   (res_q.mantis[W-2:0]),
        .count_o (lz)
    );

    // Shift is clamped so the exponent never drops below 1.
    assign lz_ext = EXP_SIZE'(lz);
    assign exp_m1 = res_q.exp - EXP_SIZE'(1);
    assign shamt  = (res_q.exp > EXP_SIZE'(1)) ? ((lz_ext < exp_m1) ? lz_ext : exp_m1)
                                                : '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            res_q   <= '0;
            small_q <= '0;
            sub_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            small_q <= small_d;
            sub_q   <= sub_d;
        end
    end

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        small_d = small_q;
        sub_d   = sub_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    res_d.sign     = sign_of_great;
                    res_d.exp      = exp;
                    res_d.mantis   = mantis_great;
                    res_d.loss     = loss_in;
                    res_d.overflow = 1'b0;
                    res_d.zero     = 1'b0;
                    small_d        = mantis_small;
                    sub_d          = sign_of_great ^ sign_of_small;
                    state_d        = ST_ADD;
                end
            end
            ST_ADD: begin
                res_d.mantis = sub_q ? (res_q.mantis - small_q) : (res_q.mantis + small_q);
                state_d      = ST_NORM;
            end
            ST_NORM: begin
                if (res_q.mantis == '0) begin
                    res_d.sign   = 1'b0;
                    res_d.exp    = '0;
                    res_d.mantis = '0;
                    res_d.zero   = 1'b1;
                    state_d      = ST_DONE;
                end else if (res_q.mantis[W-1]) begin
                    res_d.mantis = res_q.mantis >> 1;
                    res_d.loss   = res_q.loss | res_q.mantis[0];
                    if (exp_inc >= {1'b0, EXP_MAX}) begin
                        res_d.overflow = 1'b1;
                        res_d.mantis   = '0;
                        res_d.exp      = EXP_MAX;
                        state_d        = ST_DONE;
                    end else begin
                        res_d.exp = exp_inc[EXP_SIZE-1:0];
`ifdef FPA_FAST_NORM_EN
                        state_d   = ST_DONE;
`endif
                    end
`ifdef FPA_FAST_NORM_EN
                end else begin
                    res_d.mantis = res_q.mantis << shamt;
                    res_d.exp    = res_q.exp - shamt;
                    state_d      = ST_DONE;
                end
`else
                end else if (!res_q.mantis[W-2] && (res_q.exp > EXP_SIZE'(1))) begin
                    res_d.mantis = res_q.mantis << 1;
                    res_d.exp    = res_q.exp - EXP_SIZE'(1);
                end else begin
                    state_d = ST_DONE;
                end
`endif
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign sign_out   = res_q.sign;
    assign exp_out    = res_q.exp;
    assign mantis_out = res_q.mantis;
    assign loss_out   = res_q.loss;
    assign overflow   = res_q.overflow;
    assign zero       = res_q.zero;

endmodule

// File: tb/tb_mantis_add_normalize.sv
// Directed bench for mantis_add_normalize: closed-form reference model plus literal pins.
module tb_mantis_add_normalize;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic        sign_of_great, sign_of_small, loss_in;
    logic [7:0]  exp;
    logic [25:0] mantis_great, mantis_small;
    logic        sign_out, loss_out, overflow, zero;
    logic [7:0]  exp_out;
    logic [25:0] mantis_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mantis_add_normalize dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .sign_of_great (sign_of_great),
        .sign_of_small (sign_of_small),
        .exp           (exp),
        .mantis_great  (mantis_great),
        .mantis_small  (mantis_small),
        .loss_in       (loss_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .sign_out      (sign_out),
        .exp_out       (exp_out),
        .mantis_out    (mantis_out),
        .loss_out      (loss_out),
        .overflow      (overflow),
        .zero          (zero)
    );

    typedef struct {
        logic   sign;
        int     exp;
        longint mant;
        logic   loss;
        logic   ovf;
        logic   zero;
        int     ncyc;
        bit     has_lit;
        logic   l_sign;
        int     l_exp;
        longint l_mant;
        logic   l_loss;
        logic   l_ovf;
        logic   l_zero;
        bit     seen;
    } item_t;

    // Literal expectations handed from the driver to the checker at accept time.
    bit     lit_has;
    logic   lit_sign, lit_loss, lit_ovf, lit_zero;
    int     lit_exp;
    longint lit_mant;

    // Reference: exact sum, then closed-form normalization with exponent clamps.
    function automatic item_t model(input logic sg, input logic ss, input int e,
                                    input longint mg, input longint ms, input logic li);
        item_t  r;
        longint s;
        int     p, k, avail;
        s = (sg == ss) ? (mg + ms) : (mg - ms);
        r = '{default: 0};
        r.sign = sg; r.loss = li; r.ovf = 1'b0; r.zero = 1'b0;
        if (s == 0) begin
            r.sign = 1'b0; r.exp = 0; r.mant = 0; r.zero = 1'b1; r.ncyc = 1;
        end else if (s >= (64'sd1 <<< 25)) begin
            r.loss = li | s[0];
            if (e + 1 >= 255) begin
                r.ovf = 1'b1; r.exp = 255; r.mant = 0; r.ncyc = 1;
            end else begin
                r.exp = e + 1; r.mant = s / 2; r.ncyc = 2;
            end
        end else begin
            p = 0;
            for (int i = 0; i < 25; i++) if (s[i]) p = i;
            k     = 24 - p;
            avail = (e > 1) ? e - 1 : 0;
            if (k > avail) k = avail;
            r.mant = s << k; r.exp = e - k; r.ncyc = k + 1;
        end
        return r;
    endfunction

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Single checker: pushes model results on accept, compares every valid cycle.
    initial begin
        item_t q[$];
        item_t it;
        int    cnt = 0;
        bit    rst_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                rst_prev = 1'b1;
            end else begin
                if (rst_prev) begin
                    chk("rst_out_valid", out_valid, 0);
                    chk("rst_in_ready", in_ready, 1);
                    chk("rst_sign", sign_out, 0);
                    chk("rst_exp", exp_out, 0);
                    chk("rst_mantis", mantis_out, 0);
                    chk("rst_loss", loss_out, 0);
                    chk("rst_overflow", overflow, 0);
                    chk("rst_zero", zero, 0);
                    rst_prev = 1'b0;
                end
                if (q.size() != 0) begin
                    cnt++;
                    if (out_valid) begin
                        it = q[0];
                        if (!it.seen) begin
`ifdef FPA_FAST_NORM_EN
                            chk("latency", cnt, 3);
`else
                            chk("latency", cnt, it.ncyc + 2);
`endif
                            if (it.has_lit) begin
                                chk("lit_sign", sign_out, it.l_sign);
                                chk("lit_exp", exp_out, it.l_exp);
                                chk("lit_mantis", mantis_out, it.l_mant);
                                chk("lit_loss", loss_out, it.l_loss);
                                chk("lit_overflow", overflow, it.l_ovf);
                                chk("lit_zero", zero, it.l_zero);
                            end
                            q[0].seen = 1'b1;
                        end
                        chk("sign", sign_out, it.sign);
                        chk("exp", exp_out, it.exp);
                        chk("mantis", mantis_out, it.mant);
                        chk("loss", loss_out, it.loss);
                        chk("overflow", overflow, it.ovf);
                        chk("zero", zero, it.zero);
                        chk("in_ready_in_done", in_ready, 0);
                        if (out_ready) void'(q.pop_front());
                    end else if (cnt > 200) begin
                        chk("result_timeout", out_valid, 1);
                        void'(q.pop_front());
                    end
                end else if (out_valid) begin
                    chk("spurious_valid", out_valid, 0);
                end
                if (in_valid && in_ready) begin
                    it = model(sign_of_great, sign_of_small, int'(exp),
                               longint'(mantis_great), longint'(mantis_small), loss_in);
                    it.has_lit = lit_has;
                    it.l_sign = lit_sign; it.l_exp = lit_exp; it.l_mant = lit_mant;
                    it.l_loss = lit_loss; it.l_ovf = lit_ovf; it.l_zero = lit_zero;
                    it.seen = 1'b0;
                    q.push_back(it);
                    cnt = 0;
                end
            end
        end
    end

    task automatic run_op(input logic sg, input logic ss, input logic [7:0] e,
                          input logic [25:0] mg, input logic [25:0] ms, input logic li,
                          input bit has, input logic ls, input int le, input longint lm,
                          input logic ll, input logic lo, input logic lz, input bit wait_done);
        int n;
        @(posedge clk); #1;
        lit_has = has; lit_sign = ls; lit_exp = le; lit_mant = lm;
        lit_loss = ll; lit_ovf = lo; lit_zero = lz;
        sign_of_great = sg; sign_of_small = ss; exp = e;
        mantis_great = mg; mantis_small = ms; loss_in = li;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 100);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (wait_done) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!out_valid && n < 300);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        sign_of_great = 1'b0; sign_of_small = 1'b0; exp = '0;
        mantis_great = '0; mantis_small = '0; loss_in = 1'b0;
        lit_has = 1'b0; lit_sign = 1'b0; lit_exp = 0; lit_mant = 0;
        lit_loss = 1'b0; lit_ovf = 1'b0; lit_zero = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        run_op(0, 0, 8'd127, 26'h1000000, 26'h1000000, 0, 1, 0, 128, 64'h1000000, 0, 0, 0, 1);
        run_op(0, 1, 8'd127, 26'h1000000, 26'h0800000, 0, 1, 0, 126, 64'h1000000, 0, 0, 0, 1);
        run_op(1, 0, 8'd90,  26'h1234567, 26'h1234567, 0, 1, 0, 0,   64'h0,       0, 0, 1, 1);
        run_op(0, 0, 8'd254, 26'h1000000, 26'h1000000, 0, 1, 0, 255, 64'h0,       0, 1, 0, 1);
        run_op(0, 0, 8'd127, 26'h1000001, 26'h1000000, 0, 1, 0, 128, 64'h1000000, 1, 0, 0, 1);
        run_op(1, 0, 8'd3,   26'h1000000, 26'h0F00000, 0, 1, 1, 1,   64'h0400000, 0, 0, 0, 1);
        run_op(0, 1, 8'd1,   26'h0800000, 26'h0400000, 0, 1, 0, 1,   64'h0400000, 0, 0, 0, 1);
        run_op(1, 1, 8'd100, 26'h1000000, 26'h0000004, 1, 1, 1, 100, 64'h1000004, 1, 0, 0, 1);
        run_op(0, 1, 8'd200, 26'h1000000, 26'h0FFFFFF, 0, 1, 0, 176, 64'h1000000, 0, 0, 0, 1);
        run_op(1, 1, 8'd255, 26'h1000000, 26'h1000000, 0, 1, 1, 255, 64'h0,       0, 1, 0, 1);
        run_op(0, 0, 8'd10,  26'h1800000, 26'h1800000, 0, 1, 0, 11,  64'h1800000, 0, 0, 0, 1);

        // Backpressure: result must hold while in_valid pulses are refused.
        @(posedge clk); #1 out_ready = 1'b0;
        run_op(0, 1, 8'd127, 26'h1000000, 26'h0800000, 0, 1, 0, 126, 64'h1000000, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            in_valid     = ~in_valid;
            exp          = 8'(i + 40);
            mantis_great = 26'h1000000 + 26'(i);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        run_op(1, 1, 8'd100, 26'h1000000, 26'h0000004, 1, 0, 0, 0, 0, 0, 0, 0, 1);

        // Reset in the middle of a long normalization.
        run_op(0, 1, 8'd200, 26'h1000000, 26'h0FFFFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        run_op(0, 0, 8'd127, 26'h1000000, 26'h1000000, 0, 1, 0, 128, 64'h1000000, 0, 0, 0, 1);

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
